// File: rtl/wavetrace_pkg.sv
// Shared wavetrace definitions: reset sequencer state encoding and a width helper.
package wavetrace_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, both flops cleared by synchronous reset.
// Two cycles from d to q; no handshake.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer: hold, wait for PLL lock, release stages in ascending order, then ready.
// All outputs registered; asynchronous inputs pass through two-flop synchronisers first.
module reset_seq
  import wavetrace_pkg::*;
#(
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_rst_req,
  input  logic               pll_locked,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = clog2(CNT_MAX);
  localparam int IW      = clog2(NUM_OUT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  logic req_s;
  logic lock_s;

  sync_2ff u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_req),
    .q   (req_s)
  );

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [IW-1:0]      idx, idx_n;
  logic [NUM_OUT-1:0] rst_out_n;
  logic               ready_n;
  logic               abort;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    rst_out_n = rst_out;
    ready_n   = ready;

    // Lock only matters once stages have started leaving reset.
    abort = (state != HOLD) &&
            (req_s || (!lock_s && (state == RELEASE || state == RUN)));

    if (abort) begin
      state_n   = HOLD;
      cnt_n     = '0;
      idx_n     = '0;
      rst_out_n = '1;
      ready_n   = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          rst_out_n = '1;
          ready_n   = 1'b0;
          if (req_s) begin
            cnt_n = '0;
          end else if (cnt == HOLD_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_n = RELEASE;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_out_n = rst_out & ~(NUM_OUT'(1) << idx);
            cnt_n     = '0;
            idx_n     = idx + 1'b1;
            if (idx == IDX_LAST) begin
              state_n = RUN;
              ready_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RUN: begin
          rst_out_n = '0;
          ready_n   = 1'b1;
        end
        default: state_n = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      rst_out <= rst_out_n;
      ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scenario-table bench for reset_seq: per-edge expected outputs derived from release edges.
module tb_reset_seq;

  localparam int N = 3;
  localparam int H = 16;
  localparam int G = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ext_rst_req;
  logic         pll_locked;
  logic [N-1:0] rst_out;
  logic         ready;

  always #5 clk = ~clk;

  reset_seq #(
    .NUM_OUT     (N),
    .HOLD_CYCLES (H),
    .STAGE_GAP   (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_rst_req (ext_rst_req),
    .pll_locked  (pll_locked),
    .rst_out     (rst_out),
    .ready       (ready)
  );

  // Edge numbers count posedges after rst falls (edge 0 = reset phase).
  // lock_lo_*: edges at which pll_locked is sampled low; req_*: edges at which
  // ext_rst_req is sampled high; rel1/rel2: edge RELEASE is entered before/after
  // the forced re-reset at edge cut (0 = never).
  typedef struct {
    string name;
    int    n_edges;
    int    lock_lo_first;
    int    lock_lo_last;
    int    req_first;
    int    req_last;
    bit    toggle;
    int    rst_edge;
    int    rel1;
    int    cut;
    int    rel2;
  } scen_t;

  typedef struct {
    int           edge_no;
    logic [N-1:0] rst_out;
    logic         ready;
  } exp_t;

  scen_t tbl[6];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string cur_name;

  function automatic bit lock_at(scen_t s, int e);
    return !(e >= s.lock_lo_first && e <= s.lock_lo_last);
  endfunction

  function automatic bit req_at(scen_t s, int e);
    bit r;
    r = (e >= s.req_first && e <= s.req_last);
    if (s.toggle && e >= 6 && e <= 105 && (((e - 6) / 5) % 2) == 0) r = 1'b1;
    return r;
  endfunction

  function automatic exp_t expect_at(scen_t s, int e);
    exp_t x;
    int   r;
    int   st;
    r  = (s.cut != 0 && e >= s.cut) ? s.rel2 : s.rel1;
    st = 0;
    if (r != 0) begin
      for (int k = 0; k < N; k++) begin
        if (e >= r + (k + 1) * G) st++;
      end
    end
    x.edge_no = e;
    x.rst_out = '1;
    for (int k = 0; k < N; k++) begin
      if (k < st) x.rst_out[k] = 1'b0;
    end
    x.ready = (st == N);
    return x;
  endfunction

  task automatic check_front();
    exp_t x;
    x = sb.pop_front();
    checks++;
    if (rst_out !== x.rst_out || ready !== x.ready) begin
      errors++;
      $display("FAIL %s edge %0d: rst_out=%b ready=%b, expected rst_out=%b ready=%b",
               cur_name, x.edge_no, rst_out, ready, x.rst_out, x.ready);
    end
  endtask

  task automatic run_scen(scen_t s);
    exp_t r0;
    cur_name    = s.name;
    rst         = 1'b1;
    ext_rst_req = 1'b0;
    pll_locked  = lock_at(s, 0);
    r0.edge_no  = 0;
    r0.rst_out  = '1;
    r0.ready    = 1'b0;
    sb.push_back(r0);
    repeat (4) @(posedge clk);
    #1;
    check_front();
    for (int e = 1; e <= s.n_edges; e++) begin
      rst         = (e == s.rst_edge);
      ext_rst_req = req_at(s, e);
      pll_locked  = lock_at(s, e);
      sb.push_back(expect_at(s, e));
      @(posedge clk);
      #1;
      check_front();
    end
  endtask

  initial begin
    rst         = 1'b1;
    ext_rst_req = 1'b0;
    pll_locked  = 1'b1;

    //            name          edges lo_f  lo_l req_f req_l tog rst rel1 cut rel2
    tbl[0] = '{"nominal",      50,  1000, 0,  1000, 0,  1'b0, 0, 17,  0,  0};
    tbl[1] = '{"ext_pulse",    105, 1000, 0,  51,   53, 1'b0, 0, 17,  53, 72};
    tbl[2] = '{"lock_late",    65,  0,    30, 1000, 0,  1'b0, 0, 33,  0,  0};
    tbl[3] = '{"lock_loss",    90,  29,   60, 1000, 0,  1'b0, 0, 17,  31, 63};
    tbl[4] = '{"rst_mid",      85,  1000, 0,  1000, 0,  1'b0, 37, 17, 37, 54};
    tbl[5] = '{"req_toggle",   150, 1000, 0,  1000, 0,  1'b1, 0, 119, 0,  0};

    for (int i = 0; i < 6; i++) run_scen(tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
